// File: rtl/median3x3_window_ctrl.sv
// Raster-to-3x3 window sequencer for median3by3kernel: two line buffers, nine window taps
// and a sideband delay line that keeps frame/line markers aligned with the kernel output.
module median3x3_window_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8,
    parameter int KLAT  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          pixelEN,
    input  logic [DW-1:0] pix_in,
    input  logic          sof_in,
    output logic [DW-1:0] A00,
    output logic [DW-1:0] A01,
    output logic [DW-1:0] A02,
    output logic [DW-1:0] A10,
    output logic [DW-1:0] A11,
    output logic [DW-1:0] A12,
    output logic [DW-1:0] A20,
    output logic [DW-1:0] A21,
    output logic [DW-1:0] A22,
    input  logic [DW-1:0] median_in,
    output logic [DW-1:0] pix_out,
    output logic          out_valid,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof,
    output logic          busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int KW = $clog2(KLAT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [KW-1:0] CNT_LAST = KW'(KLAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    typedef struct packed {
        logic v;
        logic sof;
        logic eol;
        logic eof;
    } sb_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] win_q [3][3];
    logic [DW-1:0] win_d [3][3];
    sb_t           win_sb_q, win_sb_d;
    sb_t           dly_q [KLAT];
    sb_t           dly_d [KLAT];

    logic [DW-1:0] lb0_mem [IMG_W];
    logic [DW-1:0] lb1_mem [IMG_W];

    logic          strobe_s;
    logic          consume_s;
    logic          full_s;
    logic          last_col_s;
    logic [CW-1:0] cur_col_s;
    logic [RW-1:0] cur_row_s;
    logic [DW-1:0] lb0_rd_s;
    logic [DW-1:0] lb1_rd_s;

    // A sof_in strobe restarts at pixel (0,0) from any state.
    assign strobe_s   = en & pixelEN;
    assign consume_s  = strobe_s & (sof_in | (state_q == ST_ACTIVE));
    assign cur_col_s  = sof_in ? CW'(0) : col_q;
    assign cur_row_s  = sof_in ? RW'(0) : row_q;
    assign last_col_s = (cur_col_s == COL_LAST);
    assign full_s     = (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
    assign lb0_rd_s   = lb0_mem[cur_col_s];
    assign lb1_rd_s   = lb1_mem[cur_col_s];

    assign A00 = win_q[0][0];
    assign A01 = win_q[0][1];
    assign A02 = win_q[0][2];
    assign A10 = win_q[1][0];
    assign A11 = win_q[1][1];
    assign A12 = win_q[1][2];
    assign A20 = win_q[2][0];
    assign A21 = win_q[2][1];
    assign A22 = win_q[2][2];

    assign pix_out   = median_in;
    assign out_valid = dly_q[KLAT-1].v;
    assign out_sof   = dly_q[KLAT-1].sof;
    assign out_eol   = dly_q[KLAT-1].eol;
    assign out_eof   = dly_q[KLAT-1].eof;
    assign busy      = busy_q;

    // Next-state: position, FSM, window shift and sideband delay, all advanced only on a strobe.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        win_sb_d = win_sb_q;
        dly_d    = dly_q;
        if (strobe_s) begin
            dly_d[0] = win_sb_q;
            for (int k = 1; k < KLAT; k++) begin
                dly_d[k] = dly_q[k-1];
            end
            if (consume_s) begin
                state_d = (last_col_s && (cur_row_s == ROW_LAST)) ? ST_FLUSH : ST_ACTIVE;
                cnt_d   = KW'(0);
                if (last_col_s) begin
                    col_d = CW'(0);
                    row_d = (cur_row_s == ROW_LAST) ? RW'(0) : cur_row_s + RW'(1);
                end else begin
                    col_d = cur_col_s + CW'(1);
                    row_d = cur_row_s;
                end
                for (int r = 0; r < 3; r++) begin
                    win_d[r][0] = win_q[r][1];
                    win_d[r][1] = win_q[r][2];
                end
                win_d[0][2]  = lb1_rd_s;
                win_d[1][2]  = lb0_rd_s;
                win_d[2][2]  = pix_in;
                win_sb_d.v   = full_s;
                win_sb_d.sof = (cur_row_s == RW'(2)) && (cur_col_s == CW'(2));
                win_sb_d.eol = full_s && last_col_s;
                win_sb_d.eof = full_s && last_col_s && (cur_row_s == ROW_LAST);
            end else begin
                win_sb_d = '0;
                if (state_q == ST_FLUSH) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = KW'(0);
                    end else begin
                        cnt_d   = cnt_q + KW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, window and sideband registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            col_q    <= CW'(0);
            row_q    <= RW'(0);
            cnt_q    <= KW'(0);
            busy_q   <= 1'b0;
            win_sb_q <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= DW'(0);
                end
            end
            for (int k = 0; k < KLAT; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            win_sb_q <= win_sb_d;
            win_q    <= win_d;
            dly_q    <= dly_d;
        end
    end

    // Line buffers: read-before-write at the current column; lb1 receives the line lb0 held.
    always_ff @(posedge clk) begin
        if (consume_s) begin
            lb1_mem[cur_col_s] <= lb0_rd_s;
            lb0_mem[cur_col_s] <= pix_in;
        end
    end

endmodule

// File: tb/tb_median3x3_window_ctrl.sv
// Scoreboard bench for median3x3_window_ctrl on an 8x6 image with a 3-stage kernel stand-in.
module tb_median3x3_window_ctrl;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int KLAT = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic       pixelEN = 1'b0;
    logic       sof_in  = 1'b0;
    logic [7:0] pix_in  = 8'd0;
    logic [7:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
    logic [7:0] median_in, pix_out;
    logic       out_valid, out_sof, out_eol, out_eof, busy;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
        int         stb;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   stb_cnt = 0;
    logic s_seen = 1'b0;
    logic [7:0] k1, k2, k3;
    logic [71:0] taps_s;

    always #5 clk = ~clk;

    median3x3_window_ctrl #(.IMG_W(W), .IMG_H(H), .DW(8), .KLAT(KLAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pixelEN(pixelEN), .pix_in(pix_in), .sof_in(sof_in),
        .A00(a00), .A01(a01), .A02(a02), .A10(a10), .A11(a11), .A12(a12),
        .A20(a20), .A21(a21), .A22(a22),
        .median_in(median_in), .pix_out(pix_out), .out_valid(out_valid),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy)
    );

    assign taps_s = {a00, a01, a02, a10, a11, a12, a20, a21, a22};

    function automatic logic [7:0] med9(input logic [71:0] t);
        logic [7:0] v [9];
        logic [7:0] tmp;
        for (int i = 0; i < 9; i++) v[i] = t[i*8 +: 8];
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
                end
            end
        end
        return v[4];
    endfunction

    // Kernel stand-in: three registers advanced by the same strobe as the controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k1 <= 8'd0; k2 <= 8'd0; k3 <= 8'd0;
        end else if (en & pixelEN) begin
            k1 <= med9(taps_s); k2 <= k1; k3 <= k2;
        end
    end
    assign median_in = k3;

    always @(posedge clk) begin
        s_seen <= en & pixelEN;
        if (en & pixelEN) stb_cnt <= stb_cnt + 1;
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic monitor();
        logic [84:0] obs, snap;
        logic        snap_ok;
        exp_t        e;
        snap_ok = 1'b0;
        snap    = '0;
        forever begin
            @(negedge clk);
            obs = {pix_out, out_valid, out_sof, out_eol, out_eof, busy, taps_s};
            if (!rst_n) begin
                snap_ok = 1'b0;
            end else begin
                if (s_seen) begin
                    if (out_valid) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_extra: out_valid pix=%0d at strobe %0d, expected no output",
                                     pix_out, stb_cnt);
                        end else begin
                            e = q.pop_front();
                            if (pix_out !== e.pix || out_sof !== e.sof || out_eol !== e.eol ||
                                out_eof !== e.eof || stb_cnt != e.stb) begin
                                errors++;
                                $display("FAIL sb_out: got pix=%0d sof=%0b eol=%0b eof=%0b strobe=%0d, expected pix=%0d sof=%0b eol=%0b eof=%0b strobe=%0d",
                                         pix_out, out_sof, out_eol, out_eof, stb_cnt,
                                         e.pix, e.sof, e.eol, e.eof, e.stb);
                            end
                        end
                    end
                end else if (snap_ok) begin
                    checks++;
                    if (obs !== snap) begin
                        errors++;
                        $display("FAIL hold: outputs changed without strobe, got %0h, expected %0h", obs, snap);
                    end
                end
                snap_ok = 1'b1;
            end
            snap = obs;
        end
    endtask

    task automatic send_pixel(input logic [7:0] p, input logic sof, input bit push,
                              input logic [7:0] expv, input logic esof, input logic eeol,
                              input logic eeof, input int gap);
        exp_t e;
        en = 1'b1; pixelEN = 1'b1; pix_in = p; sof_in = sof;
        if (push) begin
            e.pix = expv; e.sof = esof; e.eol = eeol; e.eof = eeof; e.stb = stb_cnt + 1 + KLAT;
            q.push_back(e);
        end
        @(negedge clk);
        pixelEN = 1'b0; sof_in = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_idle(input int n, input int gap);
        for (int i = 0; i < n; i++) send_pixel(8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, gap);
    endtask

    // kind 0: ramp row*8+col (median = centre value); kind 1: constant 50 with 255 at (2,3).
    task automatic send_frame(input int kind, input int gap, input int pr, input int pc,
                              input int sr, input int sc);
        logic [7:0] p, ev;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == sr && c == sc) return;
                if (r == pr && c == pc) begin
                    en = 1'b0; pixelEN = 1'b1; sof_in = 1'b1; pix_in = 8'hAA;
                    repeat (10) @(negedge clk);
                    sof_in = 1'b0;
                end
                p  = (kind == 0) ? 8'(r * W + c) : ((r == 2 && c == 3) ? 8'd255 : 8'd50);
                ev = (kind == 0) ? 8'((r - 1) * W + (c - 1)) : 8'd50;
                send_pixel(p, (r == 0 && c == 0), (r >= 2 && c >= 2), ev, (r == 2 && c == 2),
                           (c == W - 1), (c == W - 1 && r == H - 1), gap);
                if (kind == 0 && r == 2 && c == 2)
                    chk("taps_first_window", 128'(taps_s),
                        128'({8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18}));
            end
        end
    endtask

    task automatic finish_frame(input int gap);
        send_idle(KLAT + 2, gap);
        chk("drain_queue_empty", 128'(q.size()), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        chk("reset_outputs", 128'({pix_out, out_valid, out_sof, out_eol, out_eof, busy, taps_s}), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp, pixel strobe every cycle; busy falls on the KLAT-th strobe after the last pixel.
        send_frame(0, 0, -1, -1, -1, -1);
        chk("busy_after_last", 128'(busy), 128'd1);
        for (int i = 1; i <= KLAT; i++) begin
            send_idle(1, 0);
            chk("busy_flush", 128'(busy), (i < KLAT) ? 128'd1 : 128'd0);
        end
        finish_frame(0);

        // Ramp, strobe every third cycle.
        send_frame(0, 2, -1, -1, -1, -1);
        finish_frame(2);

        // Constant image with a single impulse.
        send_frame(1, 0, -1, -1, -1, -1);
        finish_frame(0);

        // en held low for 10 cycles in the middle of line 3.
        send_frame(0, 0, 3, 4, -1, -1);
        finish_frame(0);

        // Resync: sof_in at (2,4) restarts the frame; the two windows in flight still drain.
        send_frame(0, 0, -1, -1, 2, 4);
        send_frame(0, 0, -1, -1, -1, -1);
        finish_frame(0);

        // Asynchronous reset mid-frame, then pixels without sof_in, then a clean frame.
        send_frame(0, 0, -1, -1, 3, 2);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs",
               128'({pix_out, out_valid, out_sof, out_eol, out_eof, busy, taps_s}), 128'd0);
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) send_pixel(8'd99, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 0);
        chk("ignored_no_busy", 128'(busy), 128'd0);
        chk("ignored_taps", 128'(taps_s), 128'd0);
        send_frame(0, 0, -1, -1, -1, -1);
        finish_frame(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
